// File: rtl/aes128_iter_top.sv
// AES-128 iterative engine: key expansion and single-block encryption, one round per clock.
// Optional macro AES_ERR_STATUS_EN flags ignored requests in status with S_ERR_MASK.
module aes128_iter_top #(
    parameter int unsigned          CTRL_S        = 32,
    parameter int unsigned          STATUS_S      = 32,
    parameter int unsigned          KEY_S         = 128,
    parameter int unsigned          BLK_S         = 128,
    parameter logic [CTRL_S-1:0]    CTRL_KEY      = 32'h1,
    parameter logic [CTRL_S-1:0]    CTRL_ENCRYPT  = 32'h2,
    parameter logic [STATUS_S-1:0]  S_KEY_MASK    = 32'h1,
    parameter logic [STATUS_S-1:0]  S_CIPHER_MASK = 32'h2
`ifdef AES_ERR_STATUS_EN
    ,
    parameter logic [STATUS_S-1:0]  S_ERR_MASK    = 32'h8000_0000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CTRL_S-1:0]   ctrl,
    input  logic [0:KEY_S-1]    aes_key,
    input  logic [0:BLK_S-1]    aes_plaintext,
    output logic [STATUS_S-1:0] status,
    output logic [0:BLK_S-1]    aes_ciphertext,
    output logic                en_o
);

    typedef enum logic [1:0] {StIdle, StKeyExp, StEnc} state_e;

    state_e                state_q, state_d;
    logic [3:0]            round_q, round_d;
    logic [127:0]          rk_q [11];
    logic [127:0]          rk_d [11];
    logic [127:0]          blk_q, blk_d;
    logic [127:0]          ct_q, ct_d;
    logic                  key_valid_q, key_valid_d;
    logic [STATUS_S-1:0]   status_q, status_d;
    logic                  en_o_q, en_o_d;
    logic [127:0]          key_w, pt_w, rk_prev, rk_cur, sb_w, nk_w;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x252, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x126 = gf_mul(x120, x6);
        x252 = gf_mul(x126, x126);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte n of the state lives at bits [127-8n -: 8]; column-major, byte index r + 4c.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign key_w = aes_key;
    assign pt_w  = aes_plaintext;

    always_comb begin
        rk_prev = '0;
        rk_cur  = '0;
        for (int i = 1; i < 11; i++) begin
            if (round_q == 4'(i)) begin
                rk_prev = rk_q[i-1];
                rk_cur  = rk_q[i];
            end
        end
    end

    assign nk_w = next_rk(rk_prev, rcon(round_q));
    assign sb_w = sub_shift(blk_q);

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        rk_d        = rk_q;
        blk_d       = blk_q;
        ct_d        = ct_q;
        key_valid_d = key_valid_q;
        status_d    = status_q;
        en_o_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    if (ctrl == CTRL_KEY) begin
                        rk_d[0]  = key_w;
                        status_d = '0;
                        round_d  = 4'd1;
                        state_d  = StKeyExp;
                    end else if (ctrl == CTRL_ENCRYPT && key_valid_q) begin
                        blk_d    = pt_w ^ rk_q[0];
                        status_d = '0;
                        round_d  = 4'd1;
                        state_d  = StEnc;
                    end else begin
`ifdef AES_ERR_STATUS_EN
                        status_d = S_ERR_MASK;
`else
                        status_d = status_q;
`endif
                    end
                end
            end
            StKeyExp: begin
                for (int i = 1; i < 11; i++) begin
                    if (round_q == 4'(i)) rk_d[i] = nk_w;
                end
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    key_valid_d = 1'b1;
                    status_d    = S_KEY_MASK;
                    round_d     = 4'd0;
                    state_d     = StIdle;
                end
            end
            StEnc: begin
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    ct_d     = sb_w ^ rk_cur;
                    en_o_d   = 1'b1;
                    status_d = S_CIPHER_MASK;
                    round_d  = 4'd0;
                    state_d  = StIdle;
                end else begin
                    blk_d = mix_columns(sb_w) ^ rk_cur;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            round_q     <= 4'd0;
            rk_q        <= '{default: '0};
            blk_q       <= '0;
            ct_q        <= '0;
            key_valid_q <= 1'b0;
            status_q    <= '0;
            en_o_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            rk_q        <= rk_d;
            blk_q       <= blk_d;
            ct_q        <= ct_d;
            key_valid_q <= key_valid_d;
            status_q    <= status_d;
            en_o_q      <= en_o_d;
        end
    end

    assign status         = status_q;
    assign aes_ciphertext = ct_q;
    assign en_o           = en_o_q;

endmodule

// File: tb/tb_aes128_iter_top.sv
// Directed bench for aes128_iter_top using FIPS-197 and well-known AES-128 vectors.
// Expectations follow AES_ERR_STATUS_EN when it is defined for the build.
module tb_aes128_iter_top;

    localparam logic [31:0] CTRL_KEY     = 32'h1;
    localparam logic [31:0] CTRL_ENCRYPT = 32'h2;
    localparam logic [31:0] S_KEY        = 32'h1;
    localparam logic [31:0] S_CIPHER     = 32'h2;
`ifdef AES_ERR_STATUS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [127:0] K1  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] PT1 = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CT1 = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K3  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [31:0]  ctrl;
    logic [0:127] aes_key;
    logic [0:127] aes_plaintext;
    logic [31:0]  status;
    logic [0:127] aes_ciphertext;
    logic         en_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses_snap;
    logic [31:0] ign_stat;

    aes128_iter_top dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .ctrl           (ctrl),
        .aes_key        (aes_key),
        .aes_plaintext  (aes_plaintext),
        .status         (status),
        .aes_ciphertext (aes_ciphertext),
        .en_o           (en_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (en_o === 1'b1) pulses++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe one command; returns 1 time unit after the posedge that samples it.
    task automatic do_cmd(input logic [31:0] c, input logic [127:0] k, input logic [127:0] p);
        @(negedge clk);
        en            = 1'b1;
        ctrl          = c;
        aes_key       = k;
        aes_plaintext = p;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; ctrl = '0; aes_key = '0; aes_plaintext = '0;
        step(3);
        check("rst_status", status, 0);
        check("rst_en_o", en_o, 0);
        check("rst_ct", aes_ciphertext, 0);
        reset = 1'b1;

        // Encrypt with no key loaded
        do_cmd(CTRL_ENCRYPT, 0, PT1);
        step(12);
        check("nokey_status", status, ERR_EN ? 32'h8000_0000 : 32'h0);
        check("nokey_pulses", pulses, 0);

        do_cmd(CTRL_KEY, K1, 0);
        step(9);
        check("key_busy_status", status, 0);
        step(1);
        check("key_done_status", status, S_KEY);

        do_cmd(CTRL_ENCRYPT, 0, PT1);
        step(9);
        check("enc_t9_en_o", en_o, 0);
        check("enc_t9_status", status, 0);
        step(1);
        check("enc_t10_en_o", en_o, 1);
        check("enc_ct1", aes_ciphertext, CT1);
        check("enc_status", status, S_CIPHER);
        step(1);
        check("enc_t11_en_o", en_o, 0);
        check("enc_ct_held", aes_ciphertext, CT1);
        check("enc_pulses", pulses, 1);

        // Unknown command
        do_cmd(32'h3, K2, PT2);
        step(3);
        ign_stat = ERR_EN ? 32'h8000_0000 : S_CIPHER;
        check("bad_ctrl_status", status, ign_stat);
        check("bad_ctrl_ct", aes_ciphertext, CT1);

        // en mid-encryption must be ignored
        do_cmd(CTRL_ENCRYPT, 0, PT1);
        step(2);
        do_cmd(CTRL_KEY, K2, PT2);
        step(6);
        check("mid_t9_en_o", en_o, 0);
        step(1);
        check("mid_en_o", en_o, 1);
        check("mid_ct", aes_ciphertext, CT1);
        check("mid_status", status, S_CIPHER);
        step(1);
        check("mid_pulses", pulses, 2);
        do_cmd(CTRL_ENCRYPT, 0, PT1);
        step(10);
        check("rk_kept_ct", aes_ciphertext, CT1);

        // Re-key with FIPS-197 vectors
        do_cmd(CTRL_KEY, K2, 0);
        step(10);
        check("rekey2_status", status, S_KEY);
        do_cmd(CTRL_ENCRYPT, 0, PT2);
        step(10);
        check("ct2", aes_ciphertext, CT2);
        do_cmd(CTRL_KEY, K3, 0);
        step(10);
        do_cmd(CTRL_ENCRYPT, 0, PT3);
        step(10);
        check("ct3", aes_ciphertext, CT3);
        check("ct3_en_o", en_o, 1);

        // Reset in the middle of an encryption
        step(1);
        pulses_snap = pulses;
        do_cmd(CTRL_ENCRYPT, 0, PT2);
        step(4);
        reset = 1'b0;
        #1;
        check("abort_status", status, 0);
        check("abort_ct", aes_ciphertext, 0);
        check("abort_en_o", en_o, 0);
        step(2);
        reset = 1'b1;
        step(10);
        check("abort_pulses", pulses, pulses_snap);
        do_cmd(CTRL_ENCRYPT, 0, PT2);
        step(12);
        check("abort_nokey_status", status, ERR_EN ? 32'h8000_0000 : 32'h0);
        check("abort_nokey_pulses", pulses, pulses_snap);
        do_cmd(CTRL_KEY, K2, 0);
        step(10);
        check("abort_rekey_status", status, S_KEY);
        do_cmd(CTRL_ENCRYPT, 0, PT2);
        step(10);
        check("abort_ct2", aes_ciphertext, CT2);
        check("abort_ct2_en_o", en_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
